// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative multiply / divide unit for the EX stage.
//
// Computes MULT/MULTU as a radix-2 shift-add (one product bit per cycle) and
// DIV/DIVU as a radix-2 restoring division (one quotient bit per cycle).
// Each operation takes DATA_WIDTH iteration cycles. The result lands in HI/LO
// on the edge that enters DONE. Division by zero skips the iterations.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   : MULT/DIV work on operand magnitudes. The signs are applied
//               on the DONE edge.
//   undefined : MULT behaves as MULTU and DIV behaves as DIVU.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        EX-stage instruction is a mul/div
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        operand A (rs), the dividend for DIV
//   src_b        operand B (rt), the divisor for DIV
//   flush        cancel the current operation
//   is_hold      stall request to PC, IF/ID and ID/EX
//   busy         an iteration is in progress
//   done         one-cycle completion pulse
//   hi, lo       HI/LO result registers
//   div_by_zero  qualifies done: the divisor was zero
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// MUL   | shift-add iteration, cnt_q = index of the bit in progress
// DIV   | restoring-division iteration, cnt_q = index of the bit in progress
// DONE  | result valid in hi/lo, done pulse, may accept a new start

module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  is_hold,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sgn_q, sgn_d;
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           dbz_q, dbz_d;

  // The signed flag comes from op[0] only when signed support is built in.
  logic sgn_req;
`ifdef MULDIV_SIGNED_EN
  assign sgn_req = ~op[0];
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign sgn_req    = 1'b0;
`endif

  // The working operands are magnitudes. For unsigned ops they equal the raw
  // operands. The raw dividend is kept for the divide-by-zero result.
  logic          neg_a, neg_b;
  logic [W-1:0]  mag_a, mag_b;
  logic [CW-1:0] bit_sel;
  logic          a_bit, b_bit;

  assign neg_a   = sgn_q & a_q[W-1];
  assign neg_b   = sgn_q & b_q[W-1];
  assign mag_a   = neg_a ? -a_q : a_q;
  assign mag_b   = neg_b ? -b_q : b_q;
  assign bit_sel = LAST - cnt_q;
  assign a_bit   = mag_a[bit_sel];
  assign b_bit   = mag_b[bit_sel];

  // Multiply, MSB first: p = 2p + (b_bit ? a : 0)
  logic [2*W-1:0] mul_step;
  assign mul_step = {p_q[2*W-2:0], 1'b0} + {{W{1'b0}}, (b_bit ? mag_a : {W{1'b0}})};

  // Restoring divide. p_q holds {remainder, partial quotient}.
  logic [W:0]     rem_sh;
  logic [W-1:0]   rem_sub;
  logic           div_ge;
  logic [2*W-1:0] div_step;
  assign rem_sh   = {p_q[2*W-1:W], a_bit};
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign rem_sub  = rem_sh[W-1:0] - mag_b;
  assign div_step = {(div_ge ? rem_sub : rem_sh[W-1:0]), p_q[W-2:0], div_ge};

  // Sign fix-up, applied on the final edge.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
  assign prod_fix = (neg_a ^ neg_b) ? -mul_step : mul_step;
  assign quo_raw  = div_step[W-1:0];
  assign rem_raw  = div_step[2*W-1:W];
  assign quo_fix  = (neg_a ^ neg_b) ? -quo_raw : quo_raw;
  assign rem_fix  = neg_a ? -rem_raw : rem_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_d     = src_a;
            b_d     = src_b;
            sgn_d   = sgn_req;
            cnt_d   = '0;
            p_d     = '0;
            state_d = op[1] ? S_DIV : S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          p_d   = mul_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d      = S_DONE;
            cnt_d        = '0;
            {hi_d, lo_d} = prod_fix;
            dbz_d        = 1'b0;
          end
        end
        S_DIV: begin
          if (b_q == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
            hi_d    = a_q;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            p_d   = div_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d = S_DONE;
              cnt_d   = '0;
              hi_d    = rem_fix;
              lo_d    = quo_fix;
              dbz_d   = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = done & dbz_q;
  assign is_hold     = (((state_q == S_IDLE) || (state_q == S_DONE)) && start) || busy;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        is_hold, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .is_hold(is_hold), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation and wait (bounded) for done. Returns the number of
  // edges after the accepting edge, or -1 if done never came.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int edges);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (done !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    n_checks++; if (is_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold_lo: got %b want 0", is_hold); end
    start = 1'b1; #1;
    n_checks++; if (is_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold_hi: got %b want 1", is_hold); end
    start = 1'b0;
    #19 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    logic hold_ok;
    op = 2'b01; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1; #1;
    n_checks++; if (is_hold !== 1'b1) begin n_fail++; $display("FAIL multu_hold_e0: got %b want 1", is_hold); end
    @(posedge clk); #1;
    start = 1'b0;
    hold_ok = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      if (is_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL multu_hold_iter: got %b want 1", hold_ok); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL multu_done_e32: got %b want 1", done); end
    n_checks++; if (is_hold !== 1'b0) begin n_fail++; $display("FAIL multu_hold_done: got %b want 0", is_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_done: got %b want 0", busy); end
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFFFFFE); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want %h", lo, 32'h00000001); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_arith();
    int e;
    logic [31:0] exp_hi, exp_lo;
    // MULT -2 x 3
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA;
`else
    exp_hi = 32'h00000002; exp_lo = 32'hFFFFFFFA;
`endif
    do_op(2'b00, 32'hFFFFFFFE, 32'h3, e);
    n_checks++; if (e !== 32) begin n_fail++; $display("FAIL mult_latency: got %0d want 32", e); end
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL mult_hi: got %h want %h", hi, exp_hi); end
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mult_lo: got %h want %h", lo, exp_lo); end
    // DIV 100 / 7, same in both builds
    do_op(2'b10, 32'd100, 32'd7, e);
    n_checks++; if (e !== 32) begin n_fail++; $display("FAIL div_latency: got %0d want 32", e); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL div_pos_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL div_pos_hi: got %h want %h", hi, 32'd2); end
    // DIV 0xFFFFFFF9 / 2
`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'hFFFFFFFD; exp_hi = 32'hFFFFFFFF;
`else
    exp_lo = 32'h7FFFFFFC; exp_hi = 32'h00000001;
`endif
    do_op(2'b10, 32'hFFFFFFF9, 32'h2, e);
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL div_neg_lo: got %h want %h", lo, exp_lo); end
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL div_neg_hi: got %h want %h", hi, exp_hi); end
    // DIVU of the same operands is always unsigned
    do_op(2'b11, 32'hFFFFFFF9, 32'h2, e);
    n_checks++; if (lo !== 32'h7FFFFFFC) begin n_fail++; $display("FAIL divu_lo: got %h want %h", lo, 32'h7FFFFFFC); end
    n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL divu_hi: got %h want %h", hi, 32'h00000001); end
    // DIV overflow case
`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'h80000000; exp_hi = 32'h0;
`else
    exp_lo = 32'h0; exp_hi = 32'h80000000;
`endif
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, e);
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL div_ovf_lo: got %h want %h", lo, exp_lo); end
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL div_ovf_hi: got %h want %h", hi, exp_hi); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_ovf_dbz: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int e;
    do_op(2'b11, 32'd100, 32'd0, e);
    n_checks++; if (e !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1", e); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    n_checks++; if (hi !== 32'h00000064) begin n_fail++; $display("FAIL dbz_hi: got %h want %h", hi, 32'h00000064); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_lo: got %h want %h", lo, 32'hFFFFFFFF); end
    @(posedge clk); #1;
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_after: got %b want 0", div_by_zero); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dbz_done_after: got %b want 0", done); end
  endtask

  task automatic test_flush();
    int e;
    logic seen_done;
    do_op(2'b01, 32'h22222222, 32'h80000001, e);
    n_checks++; if (hi !== 32'h11111111) begin n_fail++; $display("FAIL preload_hi: got %h want %h", hi, 32'h11111111); end
    n_checks++; if (lo !== 32'h22222222) begin n_fail++; $display("FAIL preload_lo: got %h want %h", lo, 32'h22222222); end
    @(posedge clk); #1;
    op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_checks++; if (is_hold !== 1'b0) begin n_fail++; $display("FAIL flush_hold: got %b want 0", is_hold); end
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", seen_done); end
    n_checks++; if (hi !== 32'h11111111) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi, 32'h11111111); end
    n_checks++; if (lo !== 32'h22222222) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo, 32'h22222222); end
  endtask

  task automatic test_reset_mid();
    int e;
    op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo: got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    do_op(2'b01, 32'd3, 32'd5, e);
    n_checks++; if (e !== 32) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 32", e); end
    n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL rstmid_lo15: got %h want %h", lo, 32'd15); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi0: got %h want 0", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int e;
    op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    // start stays high through the whole run; it must be ignored in MUL
    for (int i = 1; i <= 32; i++) begin @(posedge clk); #1; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", done); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL b2b_lo1: got %h want %h", lo, 32'd6); end
    n_checks++; if (is_hold !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_done: got %b want 1", is_hold); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", busy); end
    e = 0;
    while (done !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
    n_checks++; if (e !== 32) begin n_fail++; $display("FAIL b2b_latency2: got %0d want 32", e); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL b2b_lo2: got %h want %h", lo, 32'd6); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL b2b_hi2: got %h want 0", hi); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_arith();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
